hex_scan_driver: RTL and testbench
==================================

Name: hex_scan_driver

Overview:
- Downstream consumer of the four hex PIO output ports. Each port supplies an 8-bit active-low segment pattern, bit 7 = decimal point, reset value 8'hFF (all off).
- Time-multiplexes the four patterns onto one shared segment bus with four active-low digit enables.
- Inserts a dead-time blank between digits to suppress ghosting.
- Applies 16-level PWM brightness within each digit's lit window.

Parameters:
- SLOT_CYCLES, 50000, clocks per digit slot (1 kHz per digit at 50 MHz); must be >= 2.
- DEAD_CYCLES, 500, blanked clocks at the start of every slot; must be < SLOT_CYCLES.
- CNT_W, 16, slot counter width; must satisfy 2^CNT_W >= SLOT_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scan; 0 = blank display and restart scan
- brightness  in  4  lit duty in 16ths minus one (15 = full on)
- seg_in0  in  8  active-low pattern, digit 0 (from hex PIO 0)
- seg_in1  in  8  active-low pattern, digit 1
- seg_in2  in  8  active-low pattern, digit 2
- seg_in3  in  8  active-low pattern, digit 3
- seg_out  out  8  active-low shared segment bus
- digit_n  out  4  active-low digit enables, one-hot-low when lit
- cur_digit  out  2  index of the digit currently in its slot
- slot_tick  out  1  one-cycle pulse at each slot start

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: cnt=0, idx=0, pwm=0, seg_lat=8'hFF, bri_lat=0, seg_out=8'hFF, digit_n=4'hF, cur_digit=0, slot_tick=0.
- All outputs are registered. At each edge they are computed from the pre-edge cnt, idx, pwm and latches, so outputs lag the counter by exactly one cycle.
- Counter: when enable=1, cnt increments every clock. At cnt==SLOT_CYCLES-1 it wraps to 0 and idx increments mod 4 (3 -> 0).
- Slot start: at an edge where cnt==0, seg_lat loads seg_in[idx], bri_lat loads brightness, and pwm clears to 0.
  - Input changes mid-slot have no effect until that digit's next slot.
- Dead phase (cnt < DEAD_CYCLES): next seg_out=8'hFF, next digit_n=4'hF.
- Lit window (cnt >= DEAD_CYCLES):
  - pwm (4-bit) increments every cycle and wraps 15 -> 0.
  - If pwm <= bri_lat: next seg_out=seg_lat, next digit_n has bit idx = 0 and all others = 1.
  - Otherwise the display is blanked as in the dead phase.
- Brightness: brightness=15 gives continuous lit; brightness=0 gives 1 of every 16 cycles lit.
- slot_tick: next slot_tick = (enable && cnt==0). cur_digit registers idx, so it stays aligned with digit_n.
- enable=0: cnt, idx and pwm are synchronously cleared. Outputs are blanked on the next edge, and the latches hold.
  - On re-enable, the scan restarts at digit 0, slot start.
- Timing after reset release with enable=1:
  - slot_tick is high after edge 1.
  - The first lit output (digit 0) appears after edge DEAD_CYCLES+1.
  - cur_digit becomes 1 after edge SLOT_CYCLES+1.
- Overlap guarantee: digit_n never has more than one bit low. Between any two consecutive distinct low digits there are at least DEAD_CYCLES cycles of 4'hF.
- Reset mid-slot: all state returns to reset values immediately (asynchronous), with no glitch on digit_n beyond going to 4'hF.

Test Plan (SLOT_CYCLES=20, DEAD_CYCLES=4, CNT_W=5):
- Reset plus scan: seg_in0..3 = 8'hC0, F9, A4, B0; brightness=15; enable=1.
  - Required: digit_n = 4'hF for cycles 1-4 after release, then 4'hE with seg_out=C0 for 16 cycles.
  - Then 4 cycles of 4'hF, then 4'hD with F9; the full sequence E, D, B, 7 repeats with period 80.
- Latch timing: change seg_in0 from C0 to 8'h80 at cnt=10 of digit 0's slot.
  - Required: the current slot still shows C0; the next digit-0 slot shows 80.
- PWM: brightness=3.
  - Required: in each lit window, lit pattern = 4 cycles on, 12 off, repeated. Exactly 4 lit cycles per 16-cycle window (cnt 4-19).
- Dead-time check across the whole run.
  - Required: never more than one digit_n bit low; >= 4 cycles of 4'hF at each digit change; slot_tick pulses every 20 cycles aligned with the new cur_digit.
- Enable drop: enable=0 at digit 2, cnt=9, held 5 cycles, then enable=1.
  - Required: outputs are 8'hFF/4'hF on the next edge; the scan restarts with slot_tick and cur_digit=0, and digit 0 is lit 4 cycles later.
- Async reset mid-lit: assert reset_n=0 between edges while digit 1 is lit.
  - Required: seg_out=8'hFF, digit_n=4'hF immediately (no clock), cur_digit=0; recovery as in the first scenario.

Source files
------------

// File: rtl/hex_scan_if.sv
// hex_scan_if: signal bundle between the hex PIO side and the scan driver.
//   enable      1 = scan, 0 = blank display and restart scan
//   brightness  lit duty in 16ths minus one (15 = full on)
//   seg_in0..3  active-low segment patterns, bit 7 = decimal point
//   seg_out     active-low shared segment bus
//   digit_n     active-low digit enables, at most one low
//   cur_digit   index of the digit currently in its slot
//   slot_tick   one-cycle pulse at each slot start
// master = pattern/control source, slave = scan driver.
interface hex_scan_if;
    logic       enable;
    logic [3:0] brightness;
    logic [7:0] seg_in0;
    logic [7:0] seg_in1;
    logic [7:0] seg_in2;
    logic [7:0] seg_in3;
    logic [7:0] seg_out;
    logic [3:0] digit_n;
    logic [1:0] cur_digit;
    logic       slot_tick;

    modport master (
        output enable, brightness, seg_in0, seg_in1, seg_in2, seg_in3,
        input  seg_out, digit_n, cur_digit, slot_tick
    );

    modport slave (
        input  enable, brightness, seg_in0, seg_in1, seg_in2, seg_in3,
        output seg_out, digit_n, cur_digit, slot_tick
    );
endinterface

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexes four active-low 7-segment+DP patterns
// onto one shared segment bus with four active-low digit enables. Each
// digit slot is SLOT_CYCLES long; the first DEAD_CYCLES are blanked to
// suppress ghosting, and the remainder is PWM-dimmed in 16 steps.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      hex_scan_if.slave (enable, brightness, seg_in0..3 in;
//            seg_out, digit_n, cur_digit, slot_tick out, all registered)
module hex_scan_driver #(
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    hex_scan_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0]       pwm;
    logic [7:0]       seg_lat;
    logic [3:0]       bri_lat;

    logic [7:0]       seg_out_r;
    logic [3:0]       digit_n_r;
    logic [1:0]       cur_digit_r;
    logic             slot_tick_r;

    logic [7:0]       seg_sel;
    logic             slot_start;
    logic             in_dead;
    logic             lit;

    always_comb begin
        seg_sel = bus.seg_in0;
        case (idx)
            2'd0: seg_sel = bus.seg_in0;
            2'd1: seg_sel = bus.seg_in1;
            2'd2: seg_sel = bus.seg_in2;
            2'd3: seg_sel = bus.seg_in3;
            default: seg_sel = bus.seg_in0;
        endcase
    end

    assign slot_start = (cnt == '0);
    assign in_dead    = (cnt < CNT_DEAD);
    // pwm counts from 0 at the start of the lit window, so bri_lat=15
    // keeps every cycle lit and bri_lat=0 lights one cycle in 16.
    assign lit        = !in_dead && (pwm <= bri_lat);

    // Scan state. Latches only load at slot start so mid-slot input
    // changes wait for that digit's next slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            idx     <= 2'd0;
            pwm     <= 4'd0;
            seg_lat <= 8'hFF;
            bri_lat <= 4'd0;
        end else if (!bus.enable) begin
            cnt <= '0;
            idx <= 2'd0;
            pwm <= 4'd0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (slot_start) begin
                seg_lat <= seg_sel;
                bri_lat <= bus.brightness;
                pwm     <= 4'd0;
            end else if (!in_dead) begin
                pwm <= pwm + 4'd1;
            end
        end
    end

    // Outputs are computed from pre-edge state, so they trail cnt by one
    // cycle; cur_digit registers idx to stay aligned with digit_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_out_r   <= 8'hFF;
            digit_n_r   <= 4'hF;
            cur_digit_r <= 2'd0;
            slot_tick_r <= 1'b0;
        end else begin
            cur_digit_r <= idx;
            slot_tick_r <= bus.enable && slot_start;
            if (bus.enable && lit) begin
                seg_out_r <= seg_lat;
                digit_n_r <= ~(4'b0001 << idx);
            end else begin
                seg_out_r <= 8'hFF;
                digit_n_r <= 4'hF;
            end
        end
    end

    assign bus.seg_out   = seg_out_r;
    assign bus.digit_n   = digit_n_r;
    assign bus.cur_digit = cur_digit_r;
    assign bus.slot_tick = slot_tick_r;
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: directed test of hex_scan_driver with SLOT_CYCLES=20,
// DEAD_CYCLES=4. Expected outputs are derived from the edge count since
// the last reset release / re-enable: after edge kk the slot position is
// c=(kk-1)%20, digit d=((kk-1)/20)%4, lit when c>=4 and c-4<=brightness.
module tb_hex_scan_driver;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    hex_scan_if bus ();

    hex_scan_driver #(
        .SLOT_CYCLES (20),
        .DEAD_CYCLES (4),
        .CNT_W       (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         kk = 0;
    int         bri_exp = 15;
    logic [7:0] exp_pat [4];
    int         gap_run = 0;
    int         last_dig = -1;
    int         lit_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (kk=%0d)", tag, obs, exp, kk);
    endtask

    // Overlap and dead-time watch, independent of slot position.
    task automatic mon();
        int dd;
        dd = -1;
        chk("onehot", 32'($countones(~bus.digit_n) <= 1), 1);
        if (bus.digit_n == 4'hF) begin
            gap_run++;
        end else begin
            for (int i = 0; i < 4; i++) if (!bus.digit_n[i]) dd = i;
            if (last_dig >= 0 && dd != last_dig) chk("dead_gap", 32'(gap_run >= 4), 1);
            last_dig = dd;
            gap_run  = 0;
        end
    endtask

    task automatic step_chk();
        int c, d;
        bit lit;
        logic [3:0] dn;
        @(posedge clk);
        #1;
        kk++;
        c   = (kk - 1) % 20;
        d   = ((kk - 1) / 20) % 4;
        lit = (c >= 4) && (c - 4 <= bri_exp);
        dn  = lit ? ~(4'b0001 << d) : 4'hF;
        chk("digit_n", bus.digit_n, dn);
        chk("seg_out", bus.seg_out, lit ? exp_pat[d] : 8'hFF);
        chk("cur_digit", bus.cur_digit, d);
        chk("slot_tick", bus.slot_tick, (c == 0));
        if (c == 4) lit_cnt = 0;
        if (bus.digit_n != 4'hF) lit_cnt++;
        if (c == 19) chk("lit_per_window", lit_cnt, bri_exp + 1);
        mon();
    endtask

    task automatic step_blank();
        @(posedge clk);
        #1;
        chk("off_seg", bus.seg_out, 8'hFF);
        chk("off_digit", bus.digit_n, 4'hF);
        chk("off_tick", bus.slot_tick, 0);
        mon();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg"}, bus.seg_out, 8'hFF);
        chk({tag, "_digit"}, bus.digit_n, 4'hF);
        chk({tag, "_cur"}, bus.cur_digit, 0);
        chk({tag, "_tick"}, bus.slot_tick, 0);
    endtask

    initial begin
        bus.enable     = 1'b1;
        bus.brightness = 4'd15;
        bus.seg_in0    = 8'hC0;
        bus.seg_in1    = 8'hF9;
        bus.seg_in2    = 8'hA4;
        bus.seg_in3    = 8'hB0;
        exp_pat[0] = 8'hC0;
        exp_pat[1] = 8'hF9;
        exp_pat[2] = 8'hA4;
        exp_pat[3] = 8'hB0;

        // Reset state, then full-brightness scan.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        kk = 0;
        repeat (170) step_chk();

        // Next edge is cnt=10 of a digit-0 slot: change must wait a full scan.
        bus.seg_in0 = 8'h80;
        repeat (70) step_chk();
        exp_pat[0] = 8'h80;
        repeat (80) step_chk();

        // Dim to 4/16 from the next slot start onward.
        bus.brightness = 4'd3;
        bri_exp = 3;
        repeat (129) step_chk();

        // Next edge sees digit 2, cnt=9: drop enable for 5 edges.
        bus.enable = 1'b0;
        step_blank();
        repeat (4) begin
            step_blank();
            chk("cur_digit_off", bus.cur_digit, 0);
        end
        bus.enable = 1'b1;
        kk = 0;
        repeat (26) step_chk();

        // Digit 1 is lit now; reset between edges must blank at once.
        chk("pre_reset_lit", bus.digit_n, 4'hD);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async");
        bus.brightness = 4'd15;
        bri_exp = 15;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_vals("held");
        reset_n = 1'b1;
        kk = 0;
        repeat (100) step_chk();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
